// File: rtl/lif_neuron_array.sv
// Leaky integrate-and-fire neuron array sharing one update datapath.
// Each accepted timestep updates every neuron once, one per cycle, then reports the spike vector.
//
// state  | meaning
// IDLE   | ready for a timestep; clear_state honoured here
// UPDATE | neuron k_q is updated this cycle
// DONE   | spikes valid, out_valid pulse
module lif_neuron_array #(
    parameter int N_NEURONS   = 4,
    parameter int WIDTH       = 8,
    parameter int REFRAC_BITS = 3,
    localparam int IDX_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_NEURONS*WIDTH-1:0] in_current,
    input  logic [2:0]                 shift,
    input  logic [WIDTH-2:0]           threshold,
    input  logic                       reset_mode,
    input  logic [REFRAC_BITS-1:0]     refrac_len,
    input  logic                       clear_state,
    output logic                       out_valid,
    output logic [N_NEURONS-1:0]       spikes,
    input  logic [IDX_W-1:0]           dbg_idx,
    output logic [WIDTH-1:0]           dbg_u
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [IDX_W-1:0]           k_q, k_d;
    logic [N_NEURONS*WIDTH-1:0] cur_q, cur_d;
    logic [2:0]                 shift_q, shift_d;
    logic [WIDTH-2:0]           thr_q, thr_d;
    logic                       mode_q, mode_d;
    logic [REFRAC_BITS-1:0]     rlen_q, rlen_d;
    logic [N_NEURONS-1:0]       shadow_q, shadow_d;
    logic [N_NEURONS-1:0]       spikes_q, spikes_d;
    logic [WIDTH-1:0]           dbg_u_q, dbg_u_d;
    logic signed [WIDTH-1:0]    u_q [N_NEURONS];
    logic signed [WIDTH-1:0]    u_d [N_NEURONS];
    logic [REFRAC_BITS-1:0]     rc_q [N_NEURONS];
    logic [REFRAC_BITS-1:0]     rc_d [N_NEURONS];

    logic signed [WIDTH-1:0]    u_cur, c_cur, lu, s_sat, u_new;
    logic signed [WIDTH:0]      s_wide, thr_ext;
    logic [REFRAC_BITS-1:0]     rc_cur, rc_new;
    logic                       fire;

    // Shared datapath for the neuron selected by k_q
    always_comb begin
        u_cur   = u_q[k_q];
        rc_cur  = rc_q[k_q];
        c_cur   = cur_q[k_q*WIDTH +: WIDTH];
        lu      = (shift_q == 3'd0) ? u_cur : u_cur - (u_cur >>> shift_q);
        s_wide  = {lu[WIDTH-1], lu} + {c_cur[WIDTH-1], c_cur};
        if (s_wide[WIDTH] != s_wide[WIDTH-1])
            s_sat = s_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            s_sat = s_wide[WIDTH-1:0];
        thr_ext = {2'b00, thr_q};
        fire    = (rc_cur == '0) && ($signed({s_sat[WIDTH-1], s_sat}) >= thr_ext);
        if (rc_cur != '0) begin
            u_new  = lu;
            rc_new = rc_cur - 1'b1;
        end else if (fire) begin
            u_new  = mode_q ? '0 : s_sat - {1'b0, thr_q};
            rc_new = rlen_q;
        end else begin
            u_new  = s_sat;
            rc_new = rc_cur;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cur_d    = cur_q;
        shift_d  = shift_q;
        thr_d    = thr_q;
        mode_d   = mode_q;
        rlen_d   = rlen_q;
        shadow_d = shadow_q;
        spikes_d = spikes_q;
        u_d      = u_q;
        rc_d     = rc_q;
        case (state_q)
            S_IDLE: begin
                if (clear_state) begin
                    for (int i = 0; i < N_NEURONS; i++) begin
                        u_d[i]  = '0;
                        rc_d[i] = '0;
                    end
                end
                if (in_valid) begin
                    cur_d    = in_current;
                    shift_d  = shift;
                    thr_d    = threshold;
                    mode_d   = reset_mode;
                    rlen_d   = refrac_len;
                    k_d      = '0;
                    shadow_d = '0;
                    state_d  = S_UPDATE;
                end
            end
            S_UPDATE: begin
                u_d[k_q]      = u_new;
                rc_d[k_q]     = rc_new;
                shadow_d[k_q] = fire;
                if (k_q == IDX_W'(N_NEURONS - 1)) begin
                    // Load on entry to DONE so spikes is already valid alongside out_valid
                    spikes_d = shadow_d;
                    state_d  = S_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        dbg_u_d = (int'(dbg_idx) < N_NEURONS) ? u_q[dbg_idx] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            cur_q    <= '0;
            shift_q  <= '0;
            thr_q    <= '0;
            mode_q   <= 1'b0;
            rlen_q   <= '0;
            shadow_q <= '0;
            spikes_q <= '0;
            dbg_u_q  <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                u_q[i]  <= '0;
                rc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cur_q    <= cur_d;
            shift_q  <= shift_d;
            thr_q    <= thr_d;
            mode_q   <= mode_d;
            rlen_q   <= rlen_d;
            shadow_q <= shadow_d;
            spikes_q <= spikes_d;
            dbg_u_q  <= dbg_u_d;
            u_q      <= u_d;
            rc_q     <= rc_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign spikes    = spikes_q;
    assign dbg_u     = dbg_u_q;

endmodule
